// File: rtl/jts16_obj_buffer_pkg.sv
// rtl/jts16_obj_buffer_pkg.sv - shared constants and state encoding for the object line buffer
package jts16_obj_buffer_pkg;

  // All-ones word marks a transparent pixel; slice to the buffer width at use.
  localparam logic [31:0] TRANSP = '1;

  // Pixel nibble position inside a buffer word, identical across board variants.
  localparam int PXL_LSB = 0;
  localparam int PXL_W   = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/jts16_obj_buffer_if.sv
// rtl/jts16_obj_buffer_if.sv - draw engine to line buffer write port
interface jts16_obj_buffer_if #(
  parameter int DW = 12,
  parameter int AW = 9
);
  logic          bf_we;
  logic [AW-1:0] bf_addr;
  logic [DW-1:0] bf_data;

  modport master (output bf_we, bf_addr, bf_data);
  modport slave  (input  bf_we, bf_addr, bf_data);
endinterface

// File: rtl/jts16_obj_lbram.sv
// rtl/jts16_obj_lbram.sv - simple dual-port line RAM, one write port and one registered read port
module jts16_obj_lbram #(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read returns the pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/jts16_obj_buffer.sv
// rtl/jts16_obj_buffer.sv - double-buffered object line buffer with erase-behind readout
module jts16_obj_buffer
  import jts16_obj_buffer_pkg::*;
#(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   hstart,
  jts16_obj_buffer_if.slave      bf,
  input  logic [AW-1:0]          hdump,
  output logic [DW-1:0]          pxl,
  output logic                   init_busy
);

  localparam logic [DW-1:0] TRANSP_W = TRANSP[DW-1:0];

  state_t        state, state_nx;
  logic [AW-1:0] cnt;
  logic          wr_bank;
  logic          rd_en;
  logic          erase_q;
  logic          rd_bank_q;
  logic [AW-1:0] rd_addr_q;
  logic          rd_seen;

  logic [1:0]    ram_we;
  logic [1:0]    ram_re;
  logic [AW-1:0] ram_waddr [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];

  assign rd_en = (state == ST_RUN) && pxl_cen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      wr_bank   <= 1'b0;
      erase_q   <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      rd_seen   <= 1'b0;
    end else begin
      state   <= state_nx;
      erase_q <= rd_en;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
      if (state == ST_RUN && hstart) wr_bank <= ~wr_bank;
      // Erase bank is captured with the address so a read on the swap edge
      // still clears the bank it actually read from.
      if (rd_en) begin
        rd_addr_q <= hdump;
        rd_bank_q <= ~wr_bank;
        rd_seen   <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    init_busy = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (&cnt) state_nx = ST_RUN;
      end
      ST_RUN: state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  // A draw write wins over an erase landing on the same bank; that only
  // happens on the clk right after a swap, while the draw engine restarts.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_we[b]    = 1'b0;
      ram_waddr[b] = '0;
      ram_wdata[b] = TRANSP_W;
      ram_re[b]    = rd_en && (wr_bank != 1'(b));
      if (state == ST_INIT) begin
        ram_we[b]    = 1'b1;
        ram_waddr[b] = cnt;
      end else if (bf.bf_we && wr_bank == 1'(b)) begin
        ram_we[b]    = 1'b1;
        ram_waddr[b] = bf.bf_addr;
        ram_wdata[b] = bf.bf_data;
      end else if (erase_q && rd_bank_q == 1'(b)) begin
        ram_we[b]    = 1'b1;
        ram_waddr[b] = rd_addr_q;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jts16_obj_lbram #(.DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we[g]),
      .waddr (ram_waddr[g]),
      .wdata (ram_wdata[g]),
      .re    (ram_re[g]),
      .raddr (hdump),
      .rdata (ram_rdata[g])
    );
  end

  assign pxl = rd_seen ? ram_rdata[rd_bank_q] : TRANSP_W;

endmodule

// File: tb/tb_jts16_obj_buffer.sv
// tb/tb_jts16_obj_buffer.sv - self-checking bench for the object line buffer
module tb_jts16_obj_buffer;
  import jts16_obj_buffer_pkg::*;

  localparam int DW = 12;
  localparam int AW = 9;
  localparam logic [DW-1:0] T = 12'hFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          pxl_cen;
  logic          hstart;
  logic [AW-1:0] hdump;
  logic [DW-1:0] pxl;
  logic          init_busy;

  jts16_obj_buffer_if #(.DW(DW), .AW(AW)) bf ();

  jts16_obj_buffer #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pxl_cen   (pxl_cen),
    .hstart    (hstart),
    .bf        (bf.slave),
    .hdump     (hdump),
    .pxl       (pxl),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hs;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          cen;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [$];
  logic [DW-1:0] sb   [$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_pxl;
  int            split;

  function automatic void add(input logic hs, input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic cen,
                              input logic [AW-1:0] ra, input logic [DW-1:0] exp);
    vec_t v;
    v = '{hs: hs, we: we, wa: wa, wd: wd, cen: cen, ra: ra, exp: exp};
    if (we) assert (!(&wd[PXL_LSB +: PXL_W]));
    vecs.push_back(v);
  endfunction

  function automatic void wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    add(1'b0, 1'b1, a, d, 1'b0, '0, '0);
  endfunction

  function automatic void rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    add(1'b0, 1'b0, '0, '0, 1'b1, a, e);
  endfunction

  function automatic void hs();
    add(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endfunction

  function automatic void idle();
    add(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    pxl_cen    = 1'b0;
    hstart     = 1'b0;
    hdump      = '0;
    bf.bf_we   = 1'b0;
    bf.bf_addr = '0;
    bf.bf_data = '0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (init_busy === 1'b1 && n < 2000) begin
      if (pxl !== T) bad++;
      tick();
      n++;
    end
    check_int({tag, "_init_cycles"}, n, 512);
    check_int({tag, "_init_pxl_transp"}, bad, 0);
  endtask

  task automatic apply(input int lo, input int hi);
    logic [DW-1:0] e;
    for (int i = lo; i < hi; i++) begin
      hstart     = vecs[i].hs;
      bf.bf_we   = vecs[i].we;
      bf.bf_addr = vecs[i].wa;
      bf.bf_data = vecs[i].wd;
      pxl_cen    = vecs[i].cen;
      hdump      = vecs[i].ra;
      if (vecs[i].cen) sb.push_back(vecs[i].exp);
      tick();
      drive_idle();
      if (vecs[i].cen) begin
        e = sb.pop_front();
        check($sformatf("vec%0d_read_%0d", i, vecs[i].ra), pxl, e);
        last_pxl = e;
      end else begin
        check($sformatf("vec%0d_hold", i), pxl, last_pxl);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();

    // Line 0 after init: display bank empty, fill draw bank.
    rd(10, T);
    rd(511, T);
    wr(100, 12'h3A5);
    wr(7, 12'h201);
    wr(7, 12'h302);
    wr(0, 12'h0AB);
    wr(511, 12'h5C3);
    hs();
    // Line 1: back-to-back reads of the filled bank.
    rd(100, 12'h3A5);
    rd(101, T);
    rd(7, 12'h302);
    rd(0, 12'h0AB);
    rd(511, 12'h5C3);
    // Two consecutive swaps return to the same display bank, now erased.
    hs();
    hs();
    rd(100, T);
    rd(7, T);
    rd(511, T);
    // Same-cycle swap, write and read.
    hs();
    wr(20, 12'h444);
    hs();
    wr(30, 12'h555);
    add(1'b1, 1'b1, 5, 12'h111, 1'b1, 20, 12'h444);
    idle();
    rd(5, 12'h111);
    rd(30, 12'h555);
    hs();
    rd(20, T);
    rd(5, T);
    // Prime the draw bank before the mid-line reset.
    wr(300, 12'h7E7);
    hs();
    split = vecs.size();
    // After reset: everything transparent, draw bank is bank 0 again.
    rd(300, T);
    wr(50, 12'h123);
    hs();
    rd(50, 12'h123);
    rd(300, T);

    tick();
    tick();
    check_int("reset_init_busy", int'(init_busy), 1);
    check("reset_pxl", pxl, T);
    rst = 1'b0;
    wait_init("first");
    last_pxl = T;
    apply(0, split);

    hdump   = 300;
    pxl_cen = 1'b1;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    check_int("midline_reset_init_busy", int'(init_busy), 1);
    check("midline_reset_pxl", pxl, T);
    check_int("midline_reset_wr_bank", int'(dut.wr_bank), 0);
    wait_init("second");
    last_pxl = T;
    apply(split, vecs.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
